// File: rtl/fifo_read_master.sv
// fifo_read_master: turns FIFO status/handshake flags into single-cycle read requests and delivers captured words downstream
module fifo_read_master #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clr_stat,
    input  logic                  empty,
    input  logic                  rd_ack,
    input  logic                  rd_err,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [15:0]           rd_count,
    output logic [7:0]            err_count,
    output logic                  timeout
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Request FSM, output capture register and statistics; clr_stat is applied last so it wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rd_count  <= '0;
            err_count <= '0;
            timeout   <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                rd_count  <= rd_count + 16'd1;
            end
            case (state)
                S_IDLE: if (enable && !empty && (!out_valid || out_ready)) begin
                    state <= S_REQ;
                    rd_en <= 1'b1;
                end
                S_REQ: begin
                    state <= S_WAIT;
                    cnt   <= CW'(1);
                end
                S_WAIT: if (rd_err) begin
                    err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                    state     <= S_IDLE;
                end else if (rd_ack) begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end else if (cnt == CW'(RD_TIMEOUT)) begin
                    timeout <= 1'b1;
                    state   <= S_IDLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= S_IDLE;
            endcase
            if (clr_stat) begin
                rd_count  <= '0;
                err_count <= '0;
                timeout   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_master.sv
// tb_fifo_read_master: FIFO/consumer model with scoreboard for fifo_read_master
module tb_fifo_read_master;
    localparam int RD_TIMEOUT = 4;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

    logic        clk, reset, enable, clr_stat, empty, rd_ack, rd_err, out_ready;
    logic [31:0] rd_data, out_data;
    logic        rd_en, out_valid, timeout;
    logic [15:0] rd_count;
    logic [7:0]  err_count;

    fifo_read_master #(.DATA_WIDTH(32), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_stat(clr_stat),
        .empty(empty), .rd_ack(rd_ack), .rd_err(rd_err), .rd_data(rd_data),
        .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .rd_count(rd_count), .err_count(err_count), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = 0;
    logic [7:0]  exp_err = 0;
    logic        exp_to = 0;
    bit          ev_push = 0, ev_err = 0, ev_to = 0, pend = 0, manual = 0, prev_en = 0;
    logic [31:0] ev_word = 0;
    int          mode = 0, dly = 0, wi = 0, fmode = -1, fdly = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_cnt = 0; exp_err = 0; exp_to = 0;
        ev_push = 0; ev_err = 0; ev_to = 0; pend = 0;
    endtask

    // One clock: fold last cycle's FIFO responses into the model, then play the FIFO for the new cycle
    task automatic step();
        int r;
        @(posedge clk);
        cyc++;
        if (ev_push) exp_q.push_back(ev_word);
        if (ev_err && exp_err != 8'hFF) exp_err++;
        if (ev_to) exp_to = 1'b1;
        if (clr_stat) begin exp_cnt = 0; exp_err = 0; exp_to = 0; end
        ev_push = 0; ev_err = 0; ev_to = 0;
        #1;
        if (!manual) begin
            rd_ack = 0; rd_err = 0; rd_data = $urandom;
            if (pend) begin
                wi++;
                if (mode == M_NONE) begin
                    if (wi == RD_TIMEOUT) begin ev_to = 1; pend = 0; end
                end else if (wi == dly + 1) begin
                    pend = 0;
                    if (mode == M_ACK) begin
                        rd_ack = 1; rd_data = fifo_q.pop_front(); ev_push = 1; ev_word = rd_data;
                    end else begin
                        rd_err = 1; rd_ack = (mode == M_BOTH); ev_err = 1;
                    end
                end
            end
            if (rd_en) begin
                pend = 1; wi = 0;
                if (fmode < 0) begin
                    r = $urandom_range(0, 9);
                    mode = r < 6 ? M_ACK : r < 8 ? M_ERR : r < 9 ? M_BOTH : M_NONE;
                    dly = $urandom_range(0, 3);
                end else begin
                    mode = fmode; dly = fdly;
                end
                if (mode == M_ACK && fifo_q.size() == 0) mode = M_ERR;
            end
            empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic wait_en();
        for (int i = 0; i < 40 && !rd_en; i++) step();
        chk("wait_rd_en", 32'(rd_en), 32'(1));
    endtask

    // Scoreboard monitor: compares outputs against the model away from the active edge
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        chk("rd_count", 32'(rd_count), 32'(exp_cnt));
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("timeout", 32'(timeout), 32'(exp_to));
        chk("rd_en_pulse", 32'(rd_en && prev_en), 32'(0));
        if (out_valid && out_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_cnt++;
        end
        prev_en = rd_en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pulses[$];
        logic [31:0] held;
        reset = 1; enable = 0; clr_stat = 0; empty = 1; rd_ack = 0; rd_err = 0;
        rd_data = 0; out_ready = 0;
        step(); step();
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_timeout", 32'(timeout), 0);
        reset = 0;

        // single read
        fifo_q.push_back(32'h5); fmode = M_ACK; fdly = 0; enable = 1;
        wait_en();
        step();
        chk("single_rd_en_low", 32'(rd_en), 0);
        step();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", out_data, 32'h5);
        out_ready = 1;
        step(); step();
        chk("single_count", 32'(rd_count), 1);

        // drain 8 words
        for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
        for (int i = 0; i < 40; i++) begin
            step();
            if (rd_en) pulses.push_back(cyc);
        end
        chk("drain_pulses", 32'(pulses.size()), 8);
        for (int i = 1; i < pulses.size(); i++) chk("drain_spacing", 32'(pulses[i] - pulses[i-1]), 3);
        chk("drain_count", 32'(rd_count), 9);

        // backpressure
        out_ready = 0;
        fifo_q.push_back(32'hA5A5_0001); fifo_q.push_back(32'hA5A5_0002);
        wait_en();
        step(); step();
        held = 32'hA5A5_0001;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_no_rd_en", 32'(rd_en), 0);
            chk("bp_stable", out_data, held);
        end
        out_ready = 1;
        step();
        chk("bp_resume", 32'(rd_en), 1);
        repeat (6) step();

        // underflow errors
        clr_stat = 1; step(); clr_stat = 0;
        chk("err_clr", 32'(err_count), 0);
        fifo_q.push_back(32'h1234);
        fmode = M_ERR; fdly = 1;
        wait_en(); enable = 0;
        repeat (3) step();
        chk("err_one", 32'(err_count), 1);
        chk("err_one_valid", 32'(out_valid), 0);
        fmode = M_BOTH; fdly = 0; enable = 1;
        wait_en(); enable = 0;
        repeat (3) step();
        chk("err_two", 32'(err_count), 2);
        chk("err_two_valid", 32'(out_valid), 0);

        // timeout and clear
        fmode = M_NONE; enable = 1;
        wait_en(); enable = 0;
        repeat (4) step();
        chk("to_not_yet", 32'(timeout), 0);
        step();
        chk("to_set", 32'(timeout), 1);
        fmode = M_ACK; fdly = 0; enable = 1;
        step();
        chk("to_back_idle", 32'(rd_en), 1);
        enable = 0;
        repeat (3) step();
        clr_stat = 1; step(); clr_stat = 0;
        chk("clr_timeout", 32'(timeout), 0);
        chk("clr_rd_count", 32'(rd_count), 0);
        chk("clr_err_count", 32'(err_count), 0);

        // error counter saturation
        fifo_q.push_back(32'h77); fmode = M_ERR; fdly = 0; enable = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            wait_en();
        end
        enable = 0;
        repeat (3) step();
        chk("err_saturate", 32'(err_count), 255);

        // randomized traffic
        fmode = -1;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stat = ($urandom_range(0, 63) == 0);
            if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) fifo_q.push_back($urandom);
            step();
        end
        clr_stat = 0; enable = 0; out_ready = 1;
        repeat (10) step();

        // reset in the middle of a wait
        fifo_q.push_back(32'h0BAD_F00D); fmode = M_ACK; fdly = 2; out_ready = 0; enable = 1;
        wait_en();
        step();
        reset = 1; enable = 0; manual = 1;
        reset_model();
        #1;
        chk("mid_rst_rd_en", 32'(rd_en), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_rd_count", 32'(rd_count), 0);
        chk("mid_rst_err_count", 32'(err_count), 0);
        chk("mid_rst_timeout", 32'(timeout), 0);
        step(); step();
        reset = 0;
        rd_ack = 1; rd_data = 32'hDEAD_BEEF;
        step();
        rd_ack = 0;
        repeat (3) step();
        chk("late_ack_valid", 32'(out_valid), 0);
        chk("late_ack_data", out_data, 0);
        manual = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_read_master.md
# fifo_read_master

Read-side controller for the 8-entry operand FIFO: it turns the FIFO's status and handshake flags (`empty`, `rd_ack`, `rd_err`) into single-cycle read requests. It captures each acknowledged word into an output register and presents it to the downstream consumer (the factorial datapath) with a valid/ready handshake. It also counts delivered words and read errors, and flags a missing acknowledge.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: FIFO word / output width.
- `RD_TIMEOUT`, default 4: maximum cycles to wait for `rd_ack`/`rd_err` after a request (≥1).

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: permits new read requests.
- `clr_stat`, input, 1: synchronous clear of `rd_count`, `err_count`, `timeout`.
- `empty`, input, 1: FIFO empty flag.
- `rd_ack`, input, 1: FIFO read acknowledge.
- `rd_err`, input, 1: FIFO read-underflow error.
- `rd_data`, input, DATA_WIDTH: FIFO read data, valid while `rd_ack`=1.
- `rd_en`, output, 1: read request to FIFO, one-cycle pulse, registered.
- `out_valid`, output, 1: `out_data` holds an undelivered word.
- `out_data`, output, DATA_WIDTH: captured word.
- `out_ready`, input, 1: consumer accepts word when `out_valid`&&`out_ready`.
- `rd_count`, output, 16: words delivered downstream, wraps 0xFFFF→0.
- `err_count`, output, 8: `rd_err` events, saturates at 255.
- `timeout`, output, 1: sticky; a request received no response.

## Operation
- State machine has three states: IDLE, REQ, WAIT. Encoding is free; the state is not exported.
- IDLE→REQ when `enable` && !`empty` && (!`out_valid` || `out_ready`). Otherwise stay in IDLE.
- REQ: `rd_en`=1 for exactly this cycle. Always → WAIT, with the wait counter set to 1.
- WAIT, checked in priority order:
  1. `rd_err`=1 → `err_count`+1 (saturating). Discard `rd_data`. → IDLE.
  2. `rd_ack`=1 → `out_data`←`rd_data`, `out_valid`←1. → IDLE.
  3. counter==RD_TIMEOUT → `timeout`←1. → IDLE.
  4. otherwise counter+1, stay in WAIT.
- If `rd_ack` and `rd_err` are both 1 in the same cycle, the cycle is treated as an error: data is dropped and the error is counted.
- `rd_ack`/`rd_err` are ignored outside WAIT.
- Output register:
  - `out_valid` clears on a handshake cycle unless a new capture occurs in the same cycle, in which case it stays 1 with the new data.
  - `out_data` is stable while `out_valid`=1 and not yet accepted.
- `rd_count` increments on every `out_valid`&&`out_ready` cycle.
- `clr_stat` zeroes `rd_count`, `err_count` and `timeout`. It has priority over a same-cycle increment or set. It does not affect state, `out_valid` or `out_data`.
- Deasserting `enable` in REQ/WAIT lets the outstanding request complete; no new request is issued.
- `empty` is sampled only in IDLE. A stale `empty` leads to `rd_err`, which the error path absorbs.

## Timing
- Reset (asynchronous) values:
  - state IDLE, counter 0.
  - `rd_en`=0, `out_valid`=0, `out_data`=0.
  - `rd_count`=0, `err_count`=0, `timeout`=0.
- Reset mid-WAIT abandons the request. A late `rd_ack` arriving after reset release is ignored (the FSM is in IDLE).
- Request latency: `rd_en` goes high in the cycle after IDLE sees its condition (C+1).
- Nominal FIFO response: `rd_ack` arrives in the first WAIT cycle (C+2). `out_valid` rises at C+3.
- Minimum read period is 3 cycles per word with a continuously ready consumer. Back-to-back: IDLE may issue the next request in the cycle the current word is handshaken.
- Timeout: with no response, `timeout` rises RD_TIMEOUT cycles after the first WAIT cycle, i.e. C+2+RD_TIMEOUT.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Single read:** after reset, hold `empty`=0 and `enable`=1, and return `rd_ack`=1 with `rd_data`=0x00000005 one cycle after `rd_en`. Required: `rd_en` is a 1-cycle pulse; `out_valid`=1 with `out_data`=5 two cycles after `rd_en`; `rd_count`=1 after `out_ready`.
- **Drain 8 words:** model an 8-word FIFO, `out_ready`=1. Required: exactly 8 `rd_en` pulses at 3-cycle spacing; data delivered in order; `rd_count`=8; no further `rd_en` once `empty`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles with a word captured. Required: `out_data` stable; no `rd_en` issued; a new request goes out in the cycle `out_ready` rises.
- **Underflow error:** respond with `rd_err`=1, and in a second case `rd_err`=`rd_ack`=1. Required: `err_count` goes 0→1→2; `out_valid` stays 0.
- **Timeout and clear:** with RD_TIMEOUT=4, give no response. Required: `timeout`=1 exactly 4 cycles after the first WAIT cycle, then the FSM returns to IDLE; `clr_stat` pulse → `timeout`=0 and counters 0.
- **Reset mid-WAIT:** assert `reset` between `rd_en` and `rd_ack`. Required: all outputs go to reset values immediately; an ack arriving after reset release is ignored and `out_valid` stays 0.
